// File: rtl/apb_pkg.sv
// Shared definitions for the APB master/slave subsystem.
// Optional feature macro: APB_WAIT_STATE_EN (one slave wait state per transfer).
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 8;
  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mem_slave.sv
// Memory-mapped APB slave: word storage, PRDATA mux and PREADY generation.
// Optional feature macro: APB_WAIT_STATE_EN inserts exactly one wait state.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_wr_commit;

  assign w_wr_commit = i_psel & i_penable & i_pwrite & o_pready;

  // Storage: cleared on reset, written on the completing ACCESS edge only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_commit) begin
      r_mem[i_paddr] <= i_pwdata;
    end
  end

  assign o_prdata = (i_psel & ~i_pwrite) ? r_mem[i_paddr] : '0;

`ifdef APB_WAIT_STATE_EN
  logic r_pready;

  // Ready rises after one ACCESS cycle and falls again after the completing edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pready <= 1'b0;
    end else begin
      r_pready <= i_psel & i_penable & ~r_pready;
    end
  end

  assign o_pready = r_pready;
`else
  assign o_pready = 1'b1;
`endif

endmodule

// File: rtl/apb_master_slave.sv
// Single-transfer APB master with an on-bus memory slave; bus signals exported.
// Optional feature macro: APB_WAIT_STATE_EN (adds one wait state per transfer).
module apb_master_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
);

  apb_state_e            r_state;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_pready;
  logic                  w_psel;
  logic                  w_penable;

  assign w_psel    = (r_state != ST_IDLE);
  assign w_penable = (r_state == ST_ACCESS);

  // Master FSM plus command latch and response registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_pready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b1;
            if (!r_pwrite) begin
              r_rsp_rdata <= w_prdata;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  apb_mem_slave #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slave (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_psel    (w_psel),
    .i_penable (w_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr),
    .i_pwdata  (r_pwdata),
    .o_prdata  (w_prdata),
    .o_pready  (w_pready)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign PSEL      = w_psel;
  assign PENABLE   = w_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PRDATA    = w_prdata;
  assign PREADY    = w_pready;

endmodule

// File: tb/tb_apb_master_slave.sv
// Self-checking bench for apb_master_slave; honours APB_WAIT_STATE_EN.
module tb_apb_master_slave;

`ifdef APB_WAIT_STATE_EN
  localparam int WAIT = 1;
`else
  localparam int WAIT = 0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;

  int checks = 0;
  int failures = 0;

  // Reference model: plain word array plus last read value.
  logic [31:0] model_mem [256];
  logic [31:0] last_rd;

  apb_master_slave #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    last_rd = '0;
  endtask

  // One full transfer from the IDLE cycle up to and including the response cycle.
  // With hold set, cmd_valid stays high and command fields are scrambled while busy.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit hold);
    int n;
    int acc;
    bit got;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    if (hold) begin
      cmd_addr  = ~a;
      cmd_wdata = $urandom;
      cmd_write = ~wr;
    end else begin
      cmd_valid = 1'b0;
    end
    check("setup_psel", {31'd0, PSEL}, 32'd1);
    check("setup_penable", {31'd0, PENABLE}, 32'd0);
    check("setup_paddr", {24'd0, PADDR}, {24'd0, a});
    check("setup_pwrite", {31'd0, PWRITE}, {31'd0, wr});
    check("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    n = 0;
    acc = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        acc++;
        check("access_penable", {31'd0, PSEL & PENABLE}, 32'd1);
        check("access_paddr", {24'd0, PADDR}, {24'd0, a});
        if (acc == 1) check("first_access_pready", {31'd0, PREADY}, (WAIT != 0) ? 32'd0 : 32'd1);
        if (wr) check("access_pwdata", PWDATA, d);
        else    check("access_prdata", PRDATA, model_mem[a]);
      end
    end
    check("rsp_timeout", {31'd0, got}, 32'd1);
    check("latency_edges", n, 2 + WAIT);
    check("access_cycles", acc, 1 + WAIT);
    if (wr) model_mem[a] = d;
    else    last_rd = model_mem[a];
    check("rsp_rdata", rsp_rdata, last_rd);
    check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("done_psel", {31'd0, PSEL | PENABLE}, 32'd0);
    check("done_pwrite_hold", {31'd0, PWRITE}, {31'd0, wr});
  endtask

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    model_reset();

    // Reset then idle
    step();
    step();
    check("rst_psel", {31'd0, PSEL}, 32'd0);
    check("rst_penable", {31'd0, PENABLE}, 32'd0);
    check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    check("rst_paddr", {24'd0, PADDR}, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_pready", {31'd0, PREADY}, (WAIT != 0) ? 32'd0 : 32'd1);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    PRESETn = 1'b1;
    step();
    xfer(1'b0, 8'h10, 32'h0, 1'b0);
    check("read_0x10", rsp_rdata, 32'h0000_0000);

    // Single write; response must be a single pulse
    xfer(1'b1, 8'h05, 32'hDEAD_BEEF, 1'b0);
    step();
    check("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);

    // Write / read-back and neighbour untouched
    xfer(1'b1, 8'h3C, 32'hA5A5_A5A5, 1'b0);
    xfer(1'b0, 8'h3C, 32'h0, 1'b0);
    check("readback_0x3c", rsp_rdata, 32'hA5A5_A5A5);
    xfer(1'b0, 8'h3D, 32'h0, 1'b0);
    check("readback_0x3d", rsp_rdata, 32'h0);
    xfer(1'b0, 8'h05, 32'h0, 1'b0);
    check("readback_0x05", rsp_rdata, 32'hDEAD_BEEF);

    // Back-to-back with cmd_valid held high
    for (int i = 0; i < 4; i++) xfer(1'b1, 8'(i), 32'(i + 1), 1'b1);
    for (int i = 0; i < 4; i++) xfer(1'b0, 8'(i), 32'h0, 1'b1);
    cmd_valid = 1'b0;
    check("b2b_last_read", rsp_rdata, 32'd4);
    step();
    check("b2b_stays_idle", {31'd0, PSEL}, 32'd0);

    // Mid-transfer reset during a write ACCESS
    cmd_write = 1'b1;
    cmd_addr  = 8'h20;
    cmd_wdata = 32'h1234_5678;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    check("mid_in_access", {31'd0, PENABLE}, 32'd1);
    PRESETn = 1'b0;
    step();
    check("mid_rst_no_rsp0", {31'd0, rsp_valid}, 32'd0);
    step();
    check("mid_rst_no_rsp1", {31'd0, rsp_valid}, 32'd0);
    PRESETn = 1'b1;
    model_reset();
    step();
    check("mid_rst_no_rsp2", {31'd0, rsp_valid}, 32'd0);
    xfer(1'b0, 8'h20, 32'h0, 1'b0);
    check("mid_rst_read_0x20", rsp_rdata, 32'h0);
    xfer(1'b0, 8'h05, 32'h0, 1'b0);
    check("mem_cleared_0x05", rsp_rdata, 32'h0);

    // Wait-state scenario (latency checked inside xfer for either build)
    xfer(1'b1, 8'h01, 32'hCAFE_0001, 1'b0);
    xfer(1'b0, 8'h01, 32'h0, 1'b0);
    check("ws_readback_0x01", rsp_rdata, 32'hCAFE_0001);

    // Randomized traffic over a small address window to force reuse
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
